game_scene_ctrl: RTL and testbench

Parametrised top-level game scene controller for the FlappyBird display path; successor to the fixed three-level scene FSM. Supports NUM_LEVELS levels, qualifies every button with a configurable hold time, and generates one event per press. Remembers the origin scene for the help/cancel path and the level across pause/resume. Drives the scene code and level number consumed by the renderer and the game-logic blocks.

---
 rtl/game_scene_ctrl_if.sv | 29 ++
 rtl/game_scene_ctrl.sv | 97 +++++++++
 tb/tb_game_scene_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/game_scene_ctrl_if.sv
// game_scene_ctrl_if: button, game-logic status and scene/level outputs of the scene controller
interface game_scene_ctrl_if #(
  parameter int NUM_LEVELS = 3,
  parameter int LVL_W      = 2
);
  logic                  btn_start;
  logic                  btn_pause;
  logic                  btn_continue;
  logic                  btn_restart;
  logic                  btn_exit;
  logic                  btn_help;
  logic                  btn_cancel;
  logic [NUM_LEVELS-1:0] btn_level_sel;
  logic                  all_dead;
  logic                  level_clear;
  logic [2:0]            scene;
  logic [LVL_W-1:0]      level;
  logic                  level_start;
  modport master (
    output btn_start, btn_pause, btn_continue, btn_restart, btn_exit, btn_help, btn_cancel,
           btn_level_sel, all_dead, level_clear,
    input  scene, level, level_start
  );
  modport slave (
    input  btn_start, btn_pause, btn_continue, btn_restart, btn_exit, btn_help, btn_cancel,
           btn_level_sel, all_dead, level_clear,
    output scene, level, level_start
  );
endinterface

// File: rtl/game_scene_ctrl.sv
// game_scene_ctrl: hold-qualified buttons driving the START/PLAY/PAUSE/OVER/HELP/WIN scene FSM (clk, async active-low rst, bus: buttons + status in, scene/level/level_start out)
module game_scene_ctrl #(
  parameter int NUM_LEVELS  = 3,
  parameter int LVL_W       = 2,
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input logic              clk,
  input logic              rst,
  game_scene_ctrl_if.slave bus
);
  localparam int NB = 7 + NUM_LEVELS;
  typedef enum logic [2:0] {S_START = 3'd0, S_PLAY = 3'd1, S_PAUSE = 3'd2, S_OVER = 3'd3, S_HELP = 3'd4, S_WIN = 3'd5} scene_t;
  scene_t           scene_q, scene_d;
  logic [LVL_W-1:0] level_q, level_d, sel_lvl;
  logic             origin_q, origin_d, fresh, pend_q, ls_q;
  logic [NB-1:0]    raw, ev_d, ev_q;
  logic [CNT_W-1:0] cnt_d [NB];
  logic [CNT_W-1:0] cnt_q [NB];
  logic             ev_quit;
  assign raw = {bus.btn_level_sel, bus.btn_cancel, bus.btn_help, bus.btn_exit, bus.btn_restart,
                bus.btn_continue, bus.btn_pause, bus.btn_start};
  assign ev_quit = ev_q[3] | ev_q[4];
  // Event fires on the sample that brings the counter to HOLD_CYCLES; saturation blocks repeats until release.
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      cnt_d[b] = !raw[b] ? '0 : cnt_q[b] == CNT_W'(HOLD_CYCLES) ? cnt_q[b] : cnt_q[b] + 1'b1;
      ev_d[b]  = raw[b] && cnt_q[b] == CNT_W'(HOLD_CYCLES - 1);
    end
  end
  always_comb begin
    sel_lvl = '0;
    for (int i = NUM_LEVELS - 1; i >= 0; i--) if (ev_q[7+i]) sel_lvl = LVL_W'(i + 1);
  end
  always_comb begin
    scene_d  = scene_q;
    level_d  = level_q;
    origin_d = origin_q;
    fresh    = 1'b0;
    case (scene_q)
      S_START:
        if (ev_q[5]) begin
          scene_d  = S_HELP;
          origin_d = 1'b0;
        end else if (ev_q[0] || sel_lvl != '0) begin
          scene_d = S_PLAY;
          level_d = ev_q[0] ? LVL_W'(1) : sel_lvl;
          fresh   = 1'b1;
        end
      S_PLAY:
        if (bus.all_dead) scene_d = S_OVER;
        else if (bus.level_clear) begin
          if (level_q == LVL_W'(NUM_LEVELS)) scene_d = S_WIN;
          else begin
            level_d = level_q + 1'b1;
            fresh   = 1'b1;
          end
        end else if (ev_quit) scene_d = S_START;
        else if (ev_q[1]) scene_d = S_PAUSE;
      S_PAUSE:
        if (ev_q[2]) scene_d = S_PLAY;
        else if (ev_q[5]) begin
          scene_d  = S_HELP;
          origin_d = 1'b1;
        end else if (ev_quit) scene_d = S_START;
      S_HELP:
        if (ev_q[6]) scene_d = origin_q ? S_PAUSE : S_START;
        else if (ev_quit) scene_d = S_START;
      S_OVER, S_WIN: scene_d = ev_quit ? S_START : scene_q;
      default: scene_d = S_START;
    endcase
    if (scene_d == S_START) level_d = '0;
  end
  // level_start trails the PLAY entry by one cycle, hence the pend_q stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scene_q  <= S_START;
      level_q  <= '0;
      origin_q <= 1'b0;
      pend_q   <= 1'b0;
      ls_q     <= 1'b0;
      ev_q     <= '0;
      for (int b = 0; b < NB; b++) cnt_q[b] <= '0;
    end else begin
      scene_q  <= scene_d;
      level_q  <= level_d;
      origin_q <= origin_d;
      pend_q   <= fresh;
      ls_q     <= pend_q;
      ev_q     <= ev_d;
      for (int b = 0; b < NB; b++) cnt_q[b] <= cnt_d[b];
    end
  end
  assign bus.scene       = scene_q;
  assign bus.level       = level_q;
  assign bus.level_start = ls_q;
endmodule

// File: tb/tb_game_scene_ctrl.sv
// tb_game_scene_ctrl: directed plus randomized checks of game_scene_ctrl against a behavioural model
module tb_game_scene_ctrl;
  localparam int NL = 3;
  localparam int LW = 2;
  localparam int H  = 2;
  localparam int NB = 7 + NL;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] raw = '0;
  logic          ad = 1'b0;
  logic          lc = 1'b0;
  int            checks = 0;
  int            errs = 0;
  int            m_scene, m_level, run [NB];
  logic          m_from_pause, m_pend, m_ls;
  logic [NB-1:0] mev;
  game_scene_ctrl_if #(.NUM_LEVELS(NL), .LVL_W(LW)) bus ();
  game_scene_ctrl #(.NUM_LEVELS(NL), .LVL_W(LW), .HOLD_CYCLES(H), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  assign bus.btn_start     = raw[0];
  assign bus.btn_pause     = raw[1];
  assign bus.btn_continue  = raw[2];
  assign bus.btn_restart   = raw[3];
  assign bus.btn_exit      = raw[4];
  assign bus.btn_help      = raw[5];
  assign bus.btn_cancel    = raw[6];
  assign bus.btn_level_sel = raw[NB-1:7];
  assign bus.all_dead      = ad;
  assign bus.level_clear   = lc;
  always #5 clk = ~clk;
  task automatic expect_eq(input string tag, input logic [31:0] got, input int exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_all();
    expect_eq("scene", 32'(bus.scene), m_scene);
    expect_eq("level", 32'(bus.level), m_level);
    expect_eq("level_start", 32'(bus.level_start), int'(m_ls));
  endtask
  task automatic model_reset();
    m_scene = 0; m_level = 0; m_from_pause = 0; m_pend = 0; m_ls = 0; mev = '0;
    for (int b = 0; b < NB; b++) run[b] = 0;
  endtask
  // One clock edge of the reference: scene rules act on the events qualified so far,
  // then every button's consecutive-high run length is extended or cleared.
  task automatic model_edge();
    logic [NB-1:0] e;
    logic quit, fresh;
    int sel;
    e = mev; quit = e[3] | e[4]; fresh = 0; sel = 0;
    for (int i = NL - 1; i >= 0; i--) if (e[7+i]) sel = i + 1;
    m_ls = m_pend;
    case (m_scene)
      0: if (e[5]) begin m_scene = 4; m_from_pause = 0; end
         else if (e[0] || sel != 0) begin m_scene = 1; m_level = e[0] ? 1 : sel; fresh = 1; end
      1: if (ad) m_scene = 3;
         else if (lc) begin
           if (m_level == NL) m_scene = 5;
           else begin m_level++; fresh = 1; end
         end
         else if (quit) m_scene = 0;
         else if (e[1]) m_scene = 2;
      2: if (e[2]) m_scene = 1;
         else if (e[5]) begin m_scene = 4; m_from_pause = 1; end
         else if (quit) m_scene = 0;
      4: if (e[6]) m_scene = m_from_pause ? 2 : 0;
         else if (quit) m_scene = 0;
      default: if (quit) m_scene = 0;
    endcase
    if (m_scene == 0) m_level = 0;
    m_pend = fresh;
    for (int b = 0; b < NB; b++) begin
      run[b] = raw[b] ? run[b] + 1 : 0;
      mev[b] = (run[b] == H);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    #1 check_all();
  endtask
  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1 check_all();
    expect_eq("reset_scene", 32'(bus.scene), 0);
    expect_eq("reset_level", 32'(bus.level), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic press(input int b, input int n);
    raw[b] = 1'b1;
    repeat (n) tick();
    raw[b] = 1'b0;
    tick();
    tick();
  endtask
  task automatic clear_level();
    lc = 1'b1;
    tick();
    lc = 1'b0;
    tick();
  endtask
  initial begin
    #2 do_reset();
    press(0, 1);
    tick();
    expect_eq("short_start_scene", 32'(bus.scene), 0);
    raw[0] = 1'b1;
    repeat (3) tick();
    expect_eq("start_scene", 32'(bus.scene), 1);
    expect_eq("start_level", 32'(bus.level), 1);
    expect_eq("start_ls_early", 32'(bus.level_start), 0);
    raw[0] = 1'b0;
    tick();
    expect_eq("start_ls", 32'(bus.level_start), 1);
    tick();
    expect_eq("start_ls_once", 32'(bus.level_start), 0);
    lc = 1'b1;
    tick();
    lc = 1'b0;
    expect_eq("clear1_level", 32'(bus.level), 2);
    tick();
    expect_eq("clear1_ls", 32'(bus.level_start), 1);
    clear_level();
    expect_eq("clear2_level", 32'(bus.level), 3);
    clear_level();
    expect_eq("win_scene", 32'(bus.scene), 5);
    expect_eq("win_level", 32'(bus.level), 3);
    press(3, 2);
    expect_eq("restart_scene", 32'(bus.scene), 0);
    expect_eq("restart_level", 32'(bus.level), 0);
    press(0, 2);
    clear_level();
    press(1, 2);
    expect_eq("pause_scene", 32'(bus.scene), 2);
    expect_eq("pause_level", 32'(bus.level), 2);
    press(5, 2);
    expect_eq("help_scene", 32'(bus.scene), 4);
    press(6, 2);
    expect_eq("cancel_scene", 32'(bus.scene), 2);
    expect_eq("cancel_level", 32'(bus.level), 2);
    press(2, 2);
    expect_eq("resume_scene", 32'(bus.scene), 1);
    expect_eq("resume_level", 32'(bus.level), 2);
    expect_eq("resume_no_ls", 32'(bus.level_start), 0);
    press(4, 2);
    raw[8] = 1'b1; raw[9] = 1'b1;
    repeat (3) tick();
    raw[8] = 1'b0; raw[9] = 1'b0;
    tick();
    expect_eq("sel_scene", 32'(bus.scene), 1);
    expect_eq("sel_level", 32'(bus.level), 2);
    press(3, 2);
    raw[0] = 1'b1;
    repeat (20) tick();
    raw[0] = 1'b0;
    tick();
    expect_eq("hold_scene", 32'(bus.scene), 1);
    expect_eq("hold_level", 32'(bus.level), 1);
    ad = 1'b1; lc = 1'b1;
    tick();
    ad = 1'b0; lc = 1'b0;
    expect_eq("dead_beats_clear", 32'(bus.scene), 3);
    press(3, 2);
    press(0, 2);
    raw[1] = 1'b1; raw[3] = 1'b1;
    repeat (2) tick();
    raw[1] = 1'b0; raw[3] = 1'b0;
    tick();
    tick();
    expect_eq("restart_beats_pause", 32'(bus.scene), 0);
    press(0, 2);
    clear_level();
    clear_level();
    press(1, 2);
    expect_eq("pause3_scene", 32'(bus.scene), 2);
    expect_eq("pause3_level", 32'(bus.level), 3);
    do_reset();
    press(2, 2);
    expect_eq("continue_after_reset", 32'(bus.scene), 0);
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NB; b++) if ($urandom_range(0, 5) == 0) raw[b] = ~raw[b];
      ad = ($urandom_range(0, 40) == 0);
      lc = ($urandom_range(0, 12) == 0);
      if ($urandom_range(0, 600) == 0) do_reset();
      else tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
